// File: rtl/alu_pkg.sv
// Shared constants for the iterative rotate unit: operand width, rotate-amount
// width and the FSM state encodings. Pure declarations, no logic, no latency.
// Imported by rotate_left_iter; has no flow control of its own.
package alu_pkg;

    // Operand / result width
    localparam int DATA_W = 32;

    // Only the low AMT_W bits of the rotate amount are meaningful (mod 32)
    localparam int AMT_W  = 5;

    // Width of the rotate-amount input port
    localparam int RNUM_W = 32;

    // FSM state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // State entered from IDLE on an accepted start: a zero amount needs no
    // rotate steps and finishes straight away.
    function automatic logic [1:0] load_state(input logic [AMT_W-1:0] amt);
        return (amt != '0) ? RUN : DONE;
    endfunction

endpackage : alu_pkg

// File: rtl/rotate_step1.sv
// Single-bit rotate of a DATA_W word; left, or right when dir selection is built in (ROTATE_DIR_SEL_EN).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module rotate_step1 #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] i_data,
`ifdef ROTATE_DIR_SEL_EN
    input  logic              i_dir,
`endif
    output logic [DATA_W-1:0] o_data
);

    // One-position rotate; MSB wraps to LSB for left, LSB wraps to MSB for right
    always_comb begin
        o_data = {i_data[DATA_W-2:0], i_data[DATA_W-1]};
`ifdef ROTATE_DIR_SEL_EN
        if (i_dir) begin
            o_data = {i_data[0], i_data[DATA_W-1:1]};
        end
`endif
    end

endmodule : rotate_step1

// File: rtl/rotate_left_iter.sv
// Iterative rotate: one bit per clock, amount = r_num mod 32; optional direction port under ROTATE_DIR_SEL_EN.
// Latency: done is high in the cycle after edge k+n (n = r_num[4:0], start accepted at edge k).
// Backpressure: start is only honoured in IDLE; it is silently ignored while busy or in the done cycle.
module rotate_left_iter #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic                         start,
`ifdef ROTATE_DIR_SEL_EN
    input  logic                         dir,
`endif
    input  logic [DATA_W-1:0]            A,
    input  logic [alu_pkg::RNUM_W-1:0]   r_num,
    output logic                         busy,
    output logic                         done,
    output logic [DATA_W-1:0]            result
);

    import alu_pkg::*;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_data;
    logic [AMT_W-1:0]  r_cnt;

    logic [AMT_W-1:0]  w_amt;
    logic              w_accept;
    logic              w_last;
    logic [DATA_W-1:0] w_step;

    // Amounts of 32 and above wrap, so the upper amount bits are dropped here
    assign w_amt    = r_num[AMT_W-1:0];
    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_cnt == AMT_W'(1));

    logic w_unused_rnum_hi;
    assign w_unused_rnum_hi = ^r_num[RNUM_W-1:AMT_W];

`ifdef ROTATE_DIR_SEL_EN
    logic r_dir;

    // Direction is captured with the operand so a mid-flight change has no effect
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_dir <= 1'b0;
        end else if (w_accept) begin
            r_dir <= dir;
        end
    end

    rotate_step1 #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_data (r_data),
        .i_dir  (r_dir),
        .o_data (w_step)
    );
`else
    rotate_step1 #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_data (r_data),
        .o_data (w_step)
    );
`endif

    // FSM: IDLE -> RUN (n!=0) or DONE (n==0); RUN -> DONE after the last step; DONE -> IDLE
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= load_state(w_amt);
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Data register: load operand on accept, rotate one bit per RUN cycle, hold otherwise
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_data <= '0;
        end else if (w_accept) begin
            r_data <= A;
        end else if (r_state == RUN) begin
            r_data <= w_step;
        end
    end

    // Remaining-step counter: load amount on accept, count down through RUN
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_amt;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt - AMT_W'(1);
        end
    end

    // Outputs are decoded from state or taken straight from the data register
    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign result = r_data;

endmodule : rotate_left_iter

// File: tb/tb_rotate_left_iter.sv
// Directed bench for rotate_left_iter: reset, latency, wrap, ignored starts, abort.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every wait is bounded; the summary line is always reached.
module tb_rotate_left_iter;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] A;
    logic [31:0] r_num;
    logic        busy;
    logic        done;
    logic [31:0] result;
`ifdef ROTATE_DIR_SEL_EN
    logic        dir;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    rotate_left_iter #(
        .DATA_W (32)
    ) dut (
        .clock  (clock),
        .clear  (clear),
        .start  (start),
`ifdef ROTATE_DIR_SEL_EN
        .dir    (dir),
`endif
        .A      (A),
        .r_num  (r_num),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen_done;

        clear = 1'b1;
        start = 1'b0;
        A     = '0;
        r_num = '0;
`ifdef ROTATE_DIR_SEL_EN
        dir   = 1'b0;
`endif
        #2;
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result,        32'h0000_0000);
        tick();
        tick();
        clear = 1'b0;

        // First edge after clear release accepts start; rotate by 1
        A = 32'h8000_0001; r_num = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("r1_load_busy",   {31'd0, busy}, 32'd1);
        check("r1_load_done",   {31'd0, done}, 32'd0);
        check("r1_load_result", result,        32'h8000_0001);
        tick();
        check("r1_done",        {31'd0, done}, 32'd1);
        check("r1_result",      result,        32'h0000_0003);
        tick();
        check("r1_after_done",  {31'd0, done}, 32'd0);
        check("r1_after_busy",  {31'd0, busy}, 32'd0);
        check("r1_held",        result,        32'h0000_0003);

        // Zero amount: done in the cycle after the start edge; start in DONE ignored
        A = 32'h1234_5678; r_num = 32'd0; start = 1'b1;
        tick();
        check("r0_done",   {31'd0, done}, 32'd1);
        check("r0_busy",   {31'd0, busy}, 32'd1);
        check("r0_result", result,        32'h1234_5678);
        A = 32'hFFFF_FFFF; r_num = 32'd3;
        tick();
        start = 1'b0;
        check("r0_done_start_busy",   {31'd0, busy}, 32'd0);
        check("r0_done_start_done",   {31'd0, done}, 32'd0);
        check("r0_done_start_result", result,        32'h1234_5678);
        tick();
        check("idle_hold_busy",   {31'd0, busy}, 32'd0);
        check("idle_hold_result", result,        32'h1234_5678);

        // Amount 36 wraps to 4
        A = 32'hF000_000F; r_num = 32'd36; start = 1'b1;
        tick();
        start = 1'b0;
        check("r36_load", result, 32'hF000_000F);
        tick();
        check("r36_step1",      result,        32'hE000_001F);
        check("r36_step1_done", {31'd0, done}, 32'd0);
        wait_done(10, n);
        check("r36_latency", n,             32'd3);
        check("r36_done",    {31'd0, done}, 32'd1);
        check("r36_result",  result,        32'h0000_00FF);
        tick();

        // Amount 32 wraps to 0: immediate done, operand unchanged
        A = 32'hDEAD_BEEF; r_num = 32'd32; start = 1'b1;
        tick();
        start = 1'b0;
        check("r32_done",   {31'd0, done}, 32'd1);
        check("r32_result", result,        32'hDEAD_BEEF);
        tick();

        // Amount 31 with an ignored start mid-RUN
        A = 32'h0000_0001; r_num = 32'd31; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        A = 32'hFFFF_FFFF; r_num = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("r31_mid_busy",   {31'd0, busy}, 32'd1);
        check("r31_mid_done",   {31'd0, done}, 32'd0);
        check("r31_mid_result", result,        32'h0000_0010);
        wait_done(40, n);
        check("r31_latency", n,      32'd27);
        check("r31_result",  result, 32'h8000_0000);
        tick();
        check("r31_idle", {31'd0, busy}, 32'd0);

        // Clear during RUN aborts with no done pulse
        A = 32'h0000_0001; r_num = 32'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("abort_pre_result", result, 32'h0000_0010);
        #2;
        clear = 1'b1;
        #1;
        check("abort_busy",   {31'd0, busy}, 32'd0);
        check("abort_done",   {31'd0, done}, 32'd0);
        check("abort_result", result,        32'h0000_0000);
        tick();
        #3;
        clear = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);

        // Fresh operation after abort
        A = 32'h4000_0001; r_num = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("post_load",  result,        32'h4000_0001);
        tick();
        check("post_step1", result,        32'h8000_0002);
        check("post_step1_done", {31'd0, done}, 32'd0);
        tick();
        check("post_done",   {31'd0, done}, 32'd1);
        check("post_result", result,        32'h0000_0005);
        tick();

`ifdef ROTATE_DIR_SEL_EN
        // Right rotate; dir is captured with A so changing it afterwards has no effect
        A = 32'h0000_0001; r_num = 32'd1; dir = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        dir   = 1'b0;
        tick();
        check("dir_right_done",   {31'd0, done}, 32'd1);
        check("dir_right_result", result,        32'h8000_0000);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rotate_left_iter

// File: doc/rotate_left_iter.md
ROTATE_LEFT_ITER -- requirements
Module: rotate_left_iter

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width; rotate amount uses the low 5 bits only.
REQ-002 Port: clock, input, 1, sole clock; all state updates on the rising edge.
REQ-003 Port: clear, input, 1, reset; asynchronous and active-high.
REQ-004 Port: start, input, 1, request; sampled only in IDLE.
REQ-005 Port: A, input, 32, operand; captured on an accepted start.
REQ-006 Port: r_num, input, 32, rotate amount; only bits [4:0] are used, captured with A.
REQ-007 Port: busy, output, 1, high whenever state is not IDLE.
REQ-008 Port: done, output, 1, single-cycle completion pulse.
REQ-009 Port: result, output, 32, rotated value; valid while done is high and held until the next accepted start.

Function
REQ-010 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-011 IDLE with start=1: the block SHALL load data_reg=A and cnt=r_num[4:0]; next state is RUN if cnt!=0, else DONE.
REQ-012 IDLE with start=0: the block SHALL hold all registers.
REQ-013 RUN, each edge: data_reg = {data_reg[30:0], data_reg[31]} (rotate left by 1); cnt = cnt-1; go to DONE when cnt was 1.
REQ-014 DONE: done=1 for exactly one cycle; next state is IDLE unconditionally.
REQ-015 Latency: for n=r_num[4:0] and start accepted at edge k, done SHALL be high in the cycle after edge k+n (n=0: cycle after edge k).
REQ-016 Amounts >= 32 SHALL wrap: only r_num mod 32 is applied; r_num=32 returns A unchanged.
REQ-017 start while busy=1 SHALL be ignored, with no effect on the in-flight operation or on its operands.
REQ-018 start high in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE, the cycle after done.
REQ-019 result SHALL equal data_reg at all times and be stable outside RUN.
REQ-020 Data outputs SHALL contain no combinational path from A or r_num; all outputs are registered or decoded from state.

Reset
REQ-021 clear=1 SHALL asynchronously force state=IDLE, data_reg=0, cnt=0, busy=0, done=0, result=0.
REQ-022 clear asserted mid-RUN SHALL abort the operation and produce no done pulse; after release the block accepts start normally.
REQ-023 The first start SHALL be accepted on the first rising edge after clear deasserts.

Configuration
REQ-024 Macro ROTATE_DIR_SEL_EN: when defined, the block adds input port dir (1 bit, captured with A; 0=left, 1=right); right rotation steps as {data_reg[0], data_reg[31:1]} with identical latency.
REQ-025 Without ROTATE_DIR_SEL_EN: port dir SHALL be absent and the block SHALL rotate left only.

Structure
REQ-026 A shared package (alu_pkg) SHALL hold the DATA_W and AMT_W=5 constants and the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
REQ-027 One sub-module, rotate_step1, SHALL be the combinational single-bit rotate (with dir when ROTATE_DIR_SEL_EN is defined); FSM, counter and data register stay in rotate_left_iter.

Verification
REQ-028 A=32'h8000_0001, r_num=1, start -> done one cycle after the first RUN edge; result=32'h0000_0003.
REQ-029 A=32'h1234_5678, r_num=0 -> done in the cycle after the start edge; result=32'h1234_5678; busy high for exactly that one cycle.
REQ-030 A=32'hF000_000F, r_num=36 -> rotation by 4; result=32'h0000_00FF after 4 RUN cycles.
REQ-031 r_num=31 in flight, second start with A=32'hFFFF_FFFF mid-RUN -> ignored; result reflects the first operand only.
REQ-032 clear pulse during RUN (r_num=20, cycle 5) -> outputs zero immediately, no done; a fresh start with r_num=2 then completes correctly.
REQ-033 With ROTATE_DIR_SEL_EN defined: A=32'h0000_0001, r_num=1, dir=1 -> result=32'h8000_0000.
